// File: rtl/usr_pkg.sv
// Mode codes, FSM states and a mode-classification helper shared by the
// parametrised universal shift register and its step datapath.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Shift-type modes repeat amt times in a burst; the others act once.
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode != MODE_HOLD) && (mode != MODE_LOAD) && (mode != MODE_CLR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// One-step next-value datapath of the universal shift register, shared by the
// idle single-step path and the burst engine.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] b,
    input  logic             sr,
    input  logic             sl,
    output logic [WIDTH-1:0] q_d
);

    always_comb begin
        q_d = q;
        case (mode)
            MODE_HOLD: q_d = q;
            MODE_SHR:  q_d = {sr, q[WIDTH-1:1]};
            MODE_SHL:  q_d = {q[WIDTH-2:0], sl};
            MODE_LOAD: q_d = b;
            MODE_ROR:  q_d = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_d = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:  q_d = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_d = '0;
            default:   q_d = q;
        endcase
    end

endmodule

// File: rtl/param_shift_reg.sv
// Parametrised universal shift register with single-step operation and a
// multi-step burst engine reporting progress through busy/done.
module param_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] b,
    input  logic             sr,
    input  logic             sl,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] step_d;
    logic [2:0]       mode_q;
    logic             sr_q;
    logic             sl_q;
    logic [AMT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             idle;
    logic [2:0]       step_mode;
    logic             step_sr;
    logic             step_sl;

    // While a burst runs the step uses the latched request, never live inputs.
    assign idle      = (state_q == ST_IDLE);
    assign step_mode = idle ? s  : mode_q;
    assign step_sr   = idle ? sr : sr_q;
    assign step_sl   = idle ? sl : sl_q;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q    (q_q),
        .mode (step_mode),
        .b    (b),
        .sr   (step_sr),
        .sl   (step_sl),
        .q_d  (step_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            mode_q  <= MODE_HOLD;
            sr_q    <= 1'b0;
            sl_q    <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= s;
                        sr_q   <= sr;
                        sl_q   <= sl;
                        busy_q <= 1'b1;
                        if (is_shift_mode(s) && (amt != '0)) begin
                            count_q <= amt;
                            state_q <= ST_RUN;
                        end else begin
                            if (!is_shift_mode(s)) begin
                                q_q <= step_d;
                            end
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (en) begin
                        q_q <= step_d;
                    end
                end
                ST_RUN: begin
                    q_q     <= step_d;
                    count_q <= count_q - AMT_W'(1);
                    if (count_q == AMT_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_q;
    assign so_r = q_q[0];
    assign so_l = q_q[WIDTH-1];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg (WIDTH=8): vector table, burst
// corner cases, mid-burst reset and randomized traffic against an arithmetic model.
module tb_param_shift_reg;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic [2:0]    s;
    logic [W-1:0]  b;
    logic          sr;
    logic          sl;
    logic          start;
    logic [AW-1:0] amt;
    logic [W-1:0]  q;
    logic          soR;
    logic          soL;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] modelQ;

    typedef struct {
        logic         en;
        logic [2:0]   s;
        logic [W-1:0] b;
        logic         sr;
        logic         sl;
        logic [W-1:0] expQ;
    } vec_t;

    vec_t vecs[13];

    param_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .s     (s),
        .b     (b),
        .sr    (sr),
        .sl    (sl),
        .start (start),
        .amt   (amt),
        .q     (q),
        .so_r  (soR),
        .so_l  (soL),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference step written as plain integer arithmetic on the register value.
    function automatic logic [W-1:0] modelStep(input logic [W-1:0] cur, input logic [2:0] mode,
                                               input logic [W-1:0] ld, input logic serR, input logic serL);
        int unsigned v;
        int unsigned res;
        int unsigned top;
        v   = cur;
        top = 1 << (W - 1);
        case (mode)
            3'd1:    res = (v / 2) + (serR ? top : 0);
            3'd2:    res = ((v * 2) % (2 * top)) + (serL ? 1 : 0);
            3'd3:    res = ld;
            3'd4:    res = (v / 2) + ((v % 2) * top);
            3'd5:    res = ((v * 2) % (2 * top)) + (v / top);
            3'd6:    res = (v / 2) + ((v >= top) ? top : 0);
            3'd7:    res = 0;
            default: res = v;
        endcase
        return W'(res);
    endfunction

    function automatic bit isShift(input logic [2:0] mode);
        return mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    endfunction

    function automatic logic [W-1:0] modelBurst(input logic [W-1:0] cur, input logic [2:0] mode,
                                                input int n, input logic [W-1:0] ld,
                                                input logic serR, input logic serL);
        logic [W-1:0] v;
        v = cur;
        if (!isShift(mode)) return modelStep(v, mode, ld, serR, serL);
        for (int i = 0; i < n; i++) v = modelStep(v, mode, ld, serR, serL);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic enV, input logic [2:0] sV, input logic [W-1:0] bV,
                                 input logic srV, input logic slV, input logic startV,
                                 input logic [AW-1:0] amtV);
        en    = enV;
        s     = sV;
        b     = bV;
        sr    = srV;
        sl    = slV;
        start = startV;
        amt   = amtV;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Burst from the current model state; live inputs are scrambled while busy.
    task automatic runBurst(input string name, input logic [2:0] mode, input logic [AW-1:0] n,
                            input logic serR, input logic serL, input logic [W-1:0] ld,
                            input logic [W-1:0] expFinal);
        int steps;
        steps = isShift(mode) ? int'(n) : 0;
        applyStimulus(1'b0, mode, ld, serR, serL, 1'b1, n);
        tick();
        if (!isShift(mode)) modelQ = modelStep(modelQ, mode, ld, serR, serL);
        for (int k = 0; k <= steps + 1; k++) begin
            if (k > 0) begin
                tick();
                if (k <= steps) modelQ = modelStep(modelQ, mode, ld, serR, serL);
            end
            checkOutput({name, "_q"}, 32'(q), 32'(modelQ));
            checkOutput({name, "_busy"}, 32'(busy), (k <= steps) ? 32'd1 : 32'd0);
            checkOutput({name, "_done"}, 32'(done), (k == steps) ? 32'd1 : 32'd0);
            if (k < steps)
                applyStimulus(1'b1, 3'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                              1'b1, AW'($urandom));
            else
                applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0);
        end
        checkOutput({name, "_final"}, 32'(q), 32'(expFinal));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]    rs;
        logic [AW-1:0] ra;
        logic [W-1:0]  rb;
        logic          rr;
        logic          rl;
        logic          re;
        logic [W-1:0]  expF;

        vecs[0]  = '{1'b1, 3'b011, 8'hA5, 1'b0, 1'b0, 8'hA5};
        vecs[1]  = '{1'b1, 3'b001, 8'h00, 1'b1, 1'b0, 8'hD2};
        vecs[2]  = '{1'b1, 3'b011, 8'hA5, 1'b0, 1'b1, 8'hA5};
        vecs[3]  = '{1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'h4A};
        vecs[4]  = '{1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 8'h4A};
        vecs[5]  = '{1'b0, 3'b011, 8'hFF, 1'b1, 1'b1, 8'h4A};
        vecs[6]  = '{1'b1, 3'b100, 8'h00, 1'b1, 1'b1, 8'h25};
        vecs[7]  = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h4A};
        vecs[8]  = '{1'b1, 3'b110, 8'h00, 1'b1, 1'b1, 8'h25};
        vecs[9]  = '{1'b1, 3'b011, 8'h80, 1'b0, 1'b0, 8'h80};
        vecs[10] = '{1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'hC0};
        vecs[11] = '{1'b1, 3'b000, 8'h3C, 1'b1, 1'b1, 8'hC0};
        vecs[12] = '{1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'h00};

        rst = 1'b0;
        applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        checkOutput("rst_q", 32'(q), 32'h00);
        checkOutput("rst_so_r", 32'(soR), 32'd0);
        checkOutput("rst_so_l", 32'(soL), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        rst    = 1'b1;
        modelQ = '0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].s, vecs[i].b, vecs[i].sr, vecs[i].sl, 1'b0, '0);
            tick();
            checkOutput($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].expQ));
            checkOutput($sformatf("vec%0d_so_r", i), 32'(soR), 32'(vecs[i].expQ[0]));
            checkOutput($sformatf("vec%0d_so_l", i), 32'(soL), 32'(vecs[i].expQ[W-1]));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end
        modelQ = vecs[12].expQ;

        applyStimulus(1'b1, 3'b011, 8'h81, 1'b0, 1'b0, 1'b0, '0);
        tick();
        modelQ = 8'h81;
        runBurst("rol3", 3'b101, AW'(3), 1'b0, 1'b0, 8'h00, 8'h0C);

        applyStimulus(1'b1, 3'b011, 8'h80, 1'b0, 1'b0, 1'b0, '0);
        tick();
        modelQ = 8'h80;
        runBurst("asr8", 3'b110, AW'(8), 1'b0, 1'b0, 8'h00, 8'hFF);
        runBurst("asr0", 3'b110, AW'(0), 1'b1, 1'b1, 8'h00, 8'hFF);
        runBurst("load_burst", 3'b011, AW'(5), 1'b0, 1'b0, 8'h3C, 8'h3C);
        runBurst("clr_burst", 3'b111, AW'(2), 1'b1, 1'b1, 8'hAA, 8'h00);

        applyStimulus(1'b1, 3'b011, 8'h3C, 1'b0, 1'b0, 1'b0, '0);
        tick();
        applyStimulus(1'b0, 3'b001, 8'h00, 1'b1, 1'b0, 1'b1, AW'(6));
        tick();
        applyStimulus(1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        checkOutput("mid_q_before_rst", 32'(q), 32'hCF);
        checkOutput("mid_busy_before_rst", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_q", 32'(q), 32'h00);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        tick();
        rst    = 1'b1;
        modelQ = '0;
        runBurst("post_rst_load", 3'b011, AW'(1), 1'b0, 1'b0, 8'h0F, 8'h0F);
        runBurst("ror9", 3'b100, AW'(9), 1'b0, 1'b0, 8'h00, 8'h87);

        for (int i = 0; i < 200; i++) begin
            re = 1'($urandom);
            rs = 3'($urandom);
            rb = W'($urandom);
            rr = 1'($urandom);
            rl = 1'($urandom);
            applyStimulus(re, rs, rb, rr, rl, 1'b0, '0);
            tick();
            if (re) modelQ = modelStep(modelQ, rs, rb, rr, rl);
            checkOutput($sformatf("rand%0d_q", i), 32'(q), 32'(modelQ));
            checkOutput($sformatf("rand%0d_so", i), {30'd0, soL, soR}, {30'd0, modelQ[W-1], modelQ[0]});
        end

        for (int i = 0; i < 20; i++) begin
            rs = 3'($urandom);
            ra = AW'($urandom_range(0, (1 << AW) - 1));
            rb = W'($urandom);
            rr = 1'($urandom);
            rl = 1'($urandom);
            expF = modelBurst(modelQ, rs, int'(ra), rb, rr, rl);
            runBurst($sformatf("rburst%0d", i), rs, ra, rr, rl, rb, expF);
            if (i % 4 == 0) begin
                applyStimulus(1'b1, 3'b011, W'($urandom), 1'b0, 1'b0, 1'b0, '0);
                tick();
                modelQ = b;
                checkOutput($sformatf("rburst%0d_reload", i), 32'(q), 32'(modelQ));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
